// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor sequencer.
package serial_adder_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a client and serial_adder_ctrl.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder; the entire datapath of the serial sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full_adder reused LSB-first, carry held in a flop,
// start/busy/done handshake, result held until the next completion.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [WIDTH-2:0]     s_sh_q, s_sh_d;
  logic                 carry_q, carry_d;
  logic                 c_msb_q, c_msb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic                 fa_sum;
  logic                 fa_cout;
  logic [WIDTH-1:0]     s_full;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial sums plus the bit being produced this cycle, LSB at position 0.
  assign s_full = {fa_sum, s_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    s_sh_d   = s_sh_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the +1 rides in on the initial carry.
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_full[WIDTH-1:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          c_msb_d = fa_cout;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = s_full;
          cout_d   = fa_cout;
          ovf_d    = c_msb_q ^ fa_cout;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      s_sh_q   <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      s_sh_q   <= s_sh_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized checks of serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  logic [W-1:0] m_a, m_b;
  logic         m_c, m_s;
  logic [W-1:0] prev_r;
  logic         prev_co, prev_ov;
  int           last_done_cyc;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       output logic [W-1:0] r, output logic co, output logic ov);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (64'sd1 << (W - 1))) ? ua - (64'sd1 << W) : ua;
    sb = (ub >= (64'sd1 << (W - 1))) ? ub - (64'sd1 << W) : ub;
    if (!s) begin
      ures = ua + ub + longint'(c);
      sres = sa + sb + longint'(c);
      co   = (ures >= (64'sd1 << W));
    end else begin
      ures = ua - ub + (64'sd1 << W);
      sres = sa - sb;
      co   = (ua >= ub);
    end
    r  = W'(ures);
    ov = (sres > ((64'sd1 << (W - 1)) - 1)) || (sres < -(64'sd1 << (W - 1)));
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.sub   = s;
    bus.start = 1'b1;
    m_a = a;
    m_b = b;
    m_c = c;
    m_s = s;
  endtask

  // Consumes the capture edge, follows the run cycle by cycle, ends on the done negedge.
  task automatic complete(input int glitch_n);
    logic [W-1:0] er;
    logic         eco, eov;
    int           done_n;
    int           busy_n;
    model(m_a, m_b, m_c, m_s, er, eco, eov);
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_n = -1;
    busy_n = 0;
    for (int n = 0; n <= W + 4 && done_n < 0; n++) begin
      @(negedge clk);
      if (n == glitch_n) begin
        bus.start = 1'b1;
        bus.op_a  = 8'hAA;
      end else if (n == glitch_n + 1) begin
        bus.start = 1'b0;
      end
      check("busy", longint'(bus.busy), longint'(n < W));
      check("done", longint'(bus.done), longint'(n == W));
      if (n < W) begin
        check("held_result", longint'(bus.result), longint'(prev_r));
        check("held_cout", longint'(bus.cout), longint'(prev_co));
      end
      if (bus.busy) busy_n++;
      if (bus.done) done_n = n;
    end
    check("latency", longint'(done_n), longint'(W));
    check("busy_cycles", longint'(busy_n), longint'(W));
    check("result", longint'(bus.result), longint'(er));
    check("cout", longint'(bus.cout), longint'(eco));
    check("overflow", longint'(bus.overflow), longint'(eov));
    $display("[TB] op a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d ovf=%0d",
             m_a, m_b, m_c, m_s, bus.result, bus.cout, bus.overflow);
    prev_r        = er;
    prev_co       = eco;
    prev_ov       = eov;
    last_done_cyc = cyc;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r,
                            input logic co, input logic ov);
    check({tag, "_result"}, longint'(bus.result), longint'(r));
    check({tag, "_cout"}, longint'(bus.cout), longint'(co));
    check({tag, "_ovf"}, longint'(bus.overflow), longint'(ov));
  endtask

  task automatic idle_gap();
    @(negedge clk);
    check("idle_busy", longint'(bus.busy), 0);
    check("idle_done", longint'(bus.done), 0);
    check("idle_hold", longint'(bus.result), longint'(prev_r));
  endtask

  initial begin
    int t1;
    tests = 0;
    fails = 0;
    prev_r = '0;
    prev_co = 1'b0;
    prev_ov = 1'b0;
    last_done_cyc = 0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst_n = 1'b0;
    #1;
    expect_out("reset", 8'h00, 1'b0, 1'b0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_done", longint'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_gap();

    drive(8'h5A, 8'h3C, 1'b0, 1'b0); complete(-1);
    expect_out("add_ovf", 8'h96, 1'b0, 1'b1);
    idle_gap();
    drive(8'hFF, 8'h01, 1'b0, 1'b0); complete(-1);
    expect_out("add_wrap", 8'h00, 1'b1, 1'b0);
    idle_gap();
    drive(8'h00, 8'h00, 1'b1, 1'b0); complete(-1);
    expect_out("add_cin", 8'h01, 1'b0, 1'b0);
    idle_gap();
    drive(8'h10, 8'h20, 1'b0, 1'b1); complete(-1);
    expect_out("sub_borrow", 8'hF0, 1'b0, 1'b0);
    idle_gap();
    drive(8'h80, 8'h01, 1'b1, 1'b1); complete(-1);
    expect_out("sub_ovf", 8'h7F, 1'b1, 1'b1);
    idle_gap();

    drive(8'h01, 8'h01, 1'b0, 1'b0); complete(3);
    expect_out("start_busy", 8'h02, 1'b0, 1'b0);
    idle_gap();
    idle_gap();

    drive(8'h21, 8'h13, 1'b0, 1'b0); complete(-1);
    t1 = last_done_cyc;
    drive(8'h70, 8'h10, 1'b0, 1'b0); complete(-1);
    expect_out("b2b", 8'h80, 1'b0, 1'b1);
    check("b2b_gap", longint'(last_done_cyc - t1), longint'(W + 1));
    idle_gap();

    drive(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("abort", 8'h00, 1'b0, 1'b0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", longint'(bus.done), 0);
    end
    rst_n = 1'b1;
    prev_r = '0;
    prev_co = 1'b0;
    prev_ov = 1'b0;
    idle_gap();
    drive(8'h33, 8'h44, 1'b0, 1'b0); complete(-1);
    expect_out("after_reset", 8'h77, 1'b0, 1'b0);
    idle_gap();

    for (int i = 0; i < 40; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      complete(-1);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
